team_06_effect_engine: RTL and testbench

- Downstream audio stage of the talk/listen control FSM: consumes its current_effect[2:0] and effect_en, processes the 8-bit offset-binary mic stream, and produces the effected sample for the transmit path.
- Implements NORMAL, ECHO, TREMOLO, REVERB and SOFT on a per-sample strobe, using a circular delay buffer and a triangle LFO.
- Clears its history whenever the selected effect changes.

---
 rtl/team_06_pkg.sv | 30 +++
 rtl/team_06_delay_line.sv | 49 ++++
 rtl/team_06_effect_engine.sv | 157 +++++++++++++++
 tb/tb_team_06_effect_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_06_pkg.sv
// Shared types, constants and saturation helper for the team_06 effect engine.
package team_06_pkg;

    typedef enum logic [2:0] {
        NORMAL  = 3'd0,
        ECHO    = 3'd1,
        TREMOLO = 3'd2,
        REVERB  = 3'd3,
        SOFT    = 3'd4
    } current_effect_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } engine_state_t;

    localparam logic [7:0] SILENCE = 8'd128;

    // Clamp a signed sample to [-128,127] and return it in offset-binary form.
    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v > 18'sd127) begin
            return 8'd255;
        end else if (v < -18'sd128) begin
            return 8'd0;
        end else begin
            return {~v[7], v[6:0]};
        end
    endfunction

endpackage

// File: rtl/team_06_delay_line.sv
// Circular DEPTH x 8 sample buffer: registered read, single write port, wrapping pointer.
module team_06_delay_line
    import team_06_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ptr_clr,
    input  logic              i_adv,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    output logic [7:0]        o_rd_data,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_rd_data;
    logic [ADDR_W-1:0] w_rd_addr;

    // A read issued while the pointer is advancing must fetch the slot it is moving onto.
    assign w_rd_addr = i_adv ? (r_ptr + ADDR_W'(1)) : r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_ptr_clr) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_ptr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_ptr     = r_ptr;

endmodule

// File: rtl/team_06_effect_engine.sv
// Per-sample audio effect stage (NORMAL/ECHO/TREMOLO/REVERB/SOFT) with a 2-cycle pipeline,
// circular history buffer and triangle LFO; history is wiped whenever the effect changes.
module team_06_effect_engine
    import team_06_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LFO_DIV = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] mic_aud,
    input  logic       effect_en,
    input  logic [2:0] current_effect,
    output logic [7:0] eff_aud,
    output logic       eff_valid,
    output logic       busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

    engine_state_t     r_state;
    logic [2:0]        r_last_effect;
    logic              r_armed;
    logic [7:0]        r_lfo_p;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_vld_p1;
    logic              r_byp_p1;
    logic [7:0]        r_x_p1;
    logic              r_en_p1;

    logic              w_change;
    logic              w_clearing;
    logic              w_proc;
    logic              w_clear_done;
    logic [ADDR_W-1:0] w_ptr;
    logic [7:0]        w_d_p1;

    logic signed [17:0] w_s;
    logic signed [17:0] w_e;
    logic signed [17:0] w_g;
    logic signed [17:0] w_prod;
    logic [7:0]         w_y_p2;
    logic [7:0]         w_wr_p2;

    // The first cycle after reset only captures the effect, so it never counts as a change.
    assign w_change     = r_armed && (current_effect != r_last_effect);
    assign w_clearing   = (r_state == ST_CLEAR);
    assign w_proc       = r_vld_p1 && !r_byp_p1;
    assign w_clear_done = w_clearing && (w_ptr == ADDR_W'(DEPTH - 1));

    team_06_delay_line #(
        .DEPTH (DEPTH)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ptr_clr (w_change || w_clear_done),
        .i_adv     (w_clearing || w_proc),
        .i_wr_en   (w_clearing || w_proc),
        .i_wr_data (w_clearing ? SILENCE : w_wr_p2),
        .i_rd_en   (sample_valid && !w_clearing && !w_change),
        .o_rd_data (w_d_p1),
        .o_ptr     (w_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_CLEAR;
            busy          <= 1'b1;
            r_last_effect <= NORMAL;
            r_armed       <= 1'b0;
            r_lfo_p       <= '0;
            r_cnt         <= '0;
        end else begin
            r_last_effect <= current_effect;
            r_armed       <= 1'b1;
            if (w_change) begin
                r_state <= ST_CLEAR;
                busy    <= 1'b1;
            end else if (w_clear_done) begin
                r_state <= ST_RUN;
                busy    <= 1'b0;
            end
            if (w_change) begin
                r_lfo_p <= '0;
                r_cnt   <= '0;
            end else if (w_proc) begin
                if (r_cnt == CNT_W'(LFO_DIV - 1)) begin
                    r_cnt   <= '0;
                    r_lfo_p <= r_lfo_p + 8'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 1: latch the sample; the delay line registers the oldest history entry alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_byp_p1 <= 1'b1;
        end else begin
            r_vld_p1 <= sample_valid;
            r_byp_p1 <= w_clearing || w_change;
        end
    end

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_x_p1  <= mic_aud;
            r_en_p1 <= effect_en;
        end
    end

    always_comb begin
        w_s     = $signed({10'b0, r_x_p1}) - 18'sd128;
        w_e     = $signed({10'b0, w_d_p1}) - 18'sd128;
        w_g     = $signed({10'b0, (r_lfo_p[7] ? ~r_lfo_p[6:0] : r_lfo_p[6:0]), 1'b1});
        w_prod  = w_s * w_g;
        w_y_p2  = r_x_p1;
        w_wr_p2 = r_x_p1;
        case (r_last_effect)
            ECHO:    w_y_p2 = sat8(w_s + (w_e >>> 1));
            REVERB: begin
                w_y_p2  = sat8(w_s + (w_e >>> 1));
                w_wr_p2 = w_y_p2;
            end
            SOFT:    w_y_p2 = sat8(w_s >>> 1);
            TREMOLO: w_y_p2 = sat8(w_prod >>> 8);
            default: w_y_p2 = r_x_p1;
        endcase
        // Muted output still feeds history with the dry input, except REVERB which must decay.
        if (!r_en_p1) begin
            w_y_p2 = SILENCE;
            if (r_last_effect == REVERB) begin
                w_wr_p2 = SILENCE;
            end
        end
    end

    // Stage 2: register the result and pulse the valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_aud   <= SILENCE;
            eff_valid <= 1'b0;
        end else begin
            eff_valid <= r_vld_p1;
            if (r_vld_p1) begin
                eff_aud <= r_byp_p1 ? SILENCE : w_y_p2;
            end
        end
    end

endmodule

// File: tb/tb_team_06_effect_engine.sv
// Bench for team_06_effect_engine: sample-level reference model checked every cycle plus literal spot checks.
module tb_team_06_effect_engine;

    localparam int DEPTH   = 4;
    localparam int LFO_DIV = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] mic_aud = 8'd128;
    logic       effect_en = 1'b1;
    logic [2:0] current_effect = 3'd0;
    logic [7:0] eff_aud;
    logic       eff_valid;
    logic       busy;

    team_06_effect_engine #(
        .DEPTH   (DEPTH),
        .LFO_DIV (LFO_DIV)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .mic_aud        (mic_aud),
        .effect_en      (effect_en),
        .current_effect (current_effect),
        .eff_aud        (eff_aud),
        .eff_valid      (eff_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int y;
    } exp_t;

    exp_t       mq[$];
    int         hist[$];
    int         obs[$];
    int         edge_cnt = 0;
    int         m_since  = 0;
    int         m_n      = 0;
    int         m_out    = 128;
    logic [2:0] m_last   = 3'd0;
    bit         chk_on   = 1'b0;
    int         n_pass   = 0;
    int         n_total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic lit(input string name, input int idx, input int exp);
        if (idx < obs.size()) chk(name, obs[idx], exp);
        else chk(name, -1, exp);
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(128);
        m_since = 0;
        m_n     = 0;
    endfunction

    // Reference model: one step per clock edge, each accepted sample processed whole.
    always @(posedge clk) begin : mdl
        bit chg, run;
        int x, s, d, e, p, tri_v, g, y, w;
        edge_cnt++;
        if (!rst_n) begin
            model_reset();
            mq.delete();
            m_out  = 128;
            m_last = current_effect;
        end else begin
            chg = (current_effect != m_last);
            run = (m_since >= DEPTH) && !chg;
            if (sample_valid) begin
                y = 128;
                if (run) begin
                    x     = int'(mic_aud);
                    s     = x - 128;
                    d     = hist[0];
                    e     = d - 128;
                    p     = (m_n / LFO_DIV) % 256;
                    tri_v = (p < 128) ? p : 255 - p;
                    g     = 2 * tri_v + 1;
                    case (m_last)
                        3'd1: begin y = clamp(s + fdiv(e, 2)) + 128; w = x; end
                        3'd2: begin y = clamp(fdiv(s * g, 256)) + 128; w = x; end
                        3'd3: begin y = clamp(s + fdiv(e, 2)) + 128; w = y; end
                        3'd4: begin y = fdiv(s, 2) + 128; w = x; end
                        default: begin y = x; w = x; end
                    endcase
                    if (!effect_en) begin
                        y = 128;
                        if (m_last == 3'd3) w = 128;
                    end
                    void'(hist.pop_front());
                    hist.push_back(w);
                    m_n++;
                end
                mq.push_back('{due: edge_cnt + 1, y: y});
            end
            if (chg) begin
                m_last = current_effect;
                model_reset();
            end else if (m_since < DEPTH) begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit exp_v;
        if (chk_on) begin
            if (!rst_n) begin
                chk("rst_valid", int'(eff_valid), 0);
                chk("rst_aud", int'(eff_aud), 128);
                chk("rst_busy", int'(busy), 1);
            end else begin
                exp_v = 1'b0;
                if (mq.size() > 0 && mq[0].due == edge_cnt) begin
                    exp_v = 1'b1;
                    m_out = mq[0].y;
                    void'(mq.pop_front());
                end
                chk("valid", int'(eff_valid), int'(exp_v));
                chk("aud", int'(eff_aud), m_out);
                chk("busy", int'(busy), (m_since < DEPTH) ? 1 : 0);
                if (eff_valid) obs.push_back(int'(eff_aud));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x);
        sample_valid = 1'b1;
        mic_aud      = x;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic set_effect(input logic [2:0] e);
        current_effect = e;
        repeat (DEPTH + 2) tick();
    endtask

    task automatic busy_len(input string name);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        chk(name, cnt, DEPTH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        busy_len("busy_after_reset");
        chk("idle_aud", int'(eff_aud), 128);
        chk("idle_valid", int'(eff_valid), 0);

        // NORMAL: single sample, then back-to-back pair
        obs.delete();
        send(8'd200);
        repeat (3) tick();
        send(8'd10);
        send(8'd250);
        repeat (4) tick();
        chk("normal_cnt", obs.size(), 3);
        lit("normal_200", 0, 200);
        lit("normal_10", 1, 10);
        lit("normal_250", 2, 250);

        // ECHO impulse
        set_effect(3'd1);
        obs.delete();
        send(8'd228);
        repeat (5) send(8'd128);
        repeat (4) tick();
        lit("echo_0", 0, 228);
        lit("echo_1", 1, 128);
        lit("echo_4", 4, 178);
        lit("echo_5", 5, 128);

        // REVERB decay and saturation
        set_effect(3'd3);
        obs.delete();
        send(8'd228);
        repeat (12) send(8'd128);
        send(8'd255);
        repeat (3) send(8'd128);
        send(8'd255);
        repeat (4) tick();
        lit("reverb_4", 4, 178);
        lit("reverb_8", 8, 153);
        lit("reverb_12", 12, 140);
        lit("reverb_13", 13, 255);
        lit("reverb_sat", 17, 255);

        // SOFT and muted output
        set_effect(3'd4);
        obs.delete();
        send(8'd0);
        send(8'd255);
        effect_en = 1'b0;
        send(8'd200);
        effect_en = 1'b1;
        repeat (4) tick();
        lit("soft_0", 0, 64);
        lit("soft_255", 1, 191);
        lit("muted", 2, 128);

        // TREMOLO: g=1 right after clear, g=129 after 64*LFO_DIV samples
        set_effect(3'd2);
        obs.delete();
        send(8'd255);
        repeat (64 * LFO_DIV - 1) send(8'd128);
        send(8'd255);
        repeat (4) tick();
        lit("trem_p0", 0, 128);
        lit("trem_p64", 64 * LFO_DIV, 191);

        // ECHO -> SOFT mid-stream, then back to ECHO during the clear
        set_effect(3'd1);
        obs.delete();
        repeat (4) send(8'd228);
        current_effect = 3'd4;
        sample_valid   = 1'b1;
        mic_aud        = 8'd200;
        tick();
        sample_valid = 1'b0;
        chk("chg_busy", int'(busy), 1);
        send(8'd0);
        current_effect = 3'd1;
        tick();
        busy_len("busy_restart");
        repeat (2) tick();
        chk("switch_cnt", obs.size(), 6);
        lit("switch_pre", 3, 228);
        lit("switch_same_cycle", 4, 128);
        lit("switch_in_clear", 5, 128);
        obs.delete();
        repeat (4) send(8'd128);
        repeat (4) tick();
        lit("echo_cleared_0", 0, 128);
        lit("echo_cleared_3", 3, 128);

        // Reset during CLEAR, then reset with a sample in flight
        current_effect = 3'd2;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        busy_len("busy_reset_in_clear");
        obs.delete();
        send(8'd200);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("inflight_dropped", obs.size(), 0);
        send(8'd255);
        repeat (4) tick();
        lit("trem_after_reset", 0, 128);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
